// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: divides clk to the step rate, walks a 4- or 5-step sequence and
// emits quarter/half-frame strobes plus a sticky frame interrupt.
module apu_frame_sequencer #(
    parameter int unsigned CLKRATE = 3_579_545,
    parameter int unsigned STEP_HZ = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic       cfg_mode,
    input  logic       cfg_irq_inhibit,
    input  logic       irq_ack,
    output logic       quarter_tick,
    output logic       half_tick,
    output logic       irq,
    output logic [2:0] step
);

    localparam int unsigned DIV = CLKRATE / STEP_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    step_q, step_d;
    logic          mode_q, mode_d;
    logic          inhibit_q, inhibit_d;
    logic          quarter_q, quarter_d;
    logic          half_q, half_d;
    logic          irq_q, irq_d;

    logic          terminal_c;
    logic          dec_q_c, dec_h_c, dec_irq_c;
    logic [2:0]    last_step_c;

    // Strobe decode for the step that is completing
    always_comb begin
        dec_q_c   = 1'b0;
        dec_h_c   = 1'b0;
        dec_irq_c = 1'b0;
        case (step_q)
            3'd0: dec_q_c = 1'b1;
            3'd1: begin dec_q_c = 1'b1; dec_h_c = 1'b1; end
            3'd2: dec_q_c = 1'b1;
            3'd3: begin
                if (!mode_q) begin
                    dec_q_c   = 1'b1;
                    dec_h_c   = 1'b1;
                    dec_irq_c = !inhibit_q;
                end
            end
            3'd4: begin
                dec_q_c = mode_q;
                dec_h_c = mode_q;
            end
            default: ;
        endcase
    end

    // Next-state: prescaler, step walk, config write and irq bookkeeping
    always_comb begin
        terminal_c  = (presc_q == PRESC_LAST);
        last_step_c = mode_q ? 3'd4 : 3'd3;
        presc_d     = terminal_c ? '0 : presc_q + PW'(1);
        step_d      = step_q;
        mode_d      = mode_q;
        inhibit_d   = inhibit_q;
        quarter_d   = terminal_c & dec_q_c;
        half_d      = terminal_c & dec_h_c;
        irq_d       = (terminal_c & dec_irq_c) | (irq_q & ~irq_ack);

        if (terminal_c) begin
            step_d = (step_q == last_step_c) ? 3'd0 : step_q + 3'd1;
        end

        // A write restarts the sequence and overrides anything decoded this edge
        if (cfg_we) begin
            mode_d    = cfg_mode;
            inhibit_d = cfg_irq_inhibit;
            presc_d   = '0;
            step_d    = 3'd0;
            quarter_d = cfg_mode;
            half_d    = cfg_mode;
            irq_d     = irq_q & ~irq_ack & ~cfg_irq_inhibit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            step_q    <= 3'd0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
            irq_q     <= irq_d;
        end
    end

    assign quarter_tick = quarter_q;
    assign half_tick    = half_q;
    assign irq          = irq_q;
    assign step         = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with DIV=10 (CLKRATE=1000, STEP_HZ=100).
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic       cfg_mode;
    logic       cfg_irq_inhibit;
    logic       irq_ack;
    logic       quarter_tick;
    logic       half_tick;
    logic       irq;
    logic [2:0] step;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    apu_frame_sequencer #(.CLKRATE(1000), .STEP_HZ(100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_mode       (cfg_mode),
        .cfg_irq_inhibit(cfg_irq_inhibit),
        .irq_ack        (irq_ack),
        .quarter_tick   (quarter_tick),
        .half_tick      (half_tick),
        .irq            (irq),
        .step           (step)
    );

    always #5 clk = ~clk;

    // Advance into the next cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset, then release so that the current cycle is cycle 0
    task automatic do_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 1'b0; cfg_irq_inhibit = 1'b0; irq_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({quarter_tick, half_tick, irq, step} !== 6'b000_000) begin
            n_fail++;
            $display("FAIL reset_state got q=%b h=%b irq=%b step=%0d exp all 0", quarter_tick, half_tick, irq, step);
        end
    endtask

    task automatic test_four_step();
        logic exp_q, exp_h, exp_irq;
        logic [2:0] exp_step;
        do_reset();
        while (cyc < 55) begin
            tick();
            exp_q    = (cyc % 10 == 0);
            exp_h    = (cyc % 20 == 0);
            exp_irq  = (cyc >= 40);
            exp_step = 3'((cyc / 10) % 4);
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== exp_h || irq !== exp_irq) begin
                n_fail++;
                $display("FAIL four_step cyc=%0d got q=%b h=%b irq=%b exp q=%b h=%b irq=%b",
                         cyc, quarter_tick, half_tick, irq, exp_q, exp_h, exp_irq);
            end
            if (exp_q) begin
                n_tests++;
                if (step !== exp_step) begin
                    n_fail++;
                    $display("FAIL four_step_idx cyc=%0d got step=%0d exp %0d", cyc, step, exp_step);
                end
            end
        end
    endtask

    task automatic test_five_step();
        logic exp_q, exp_h;
        do_reset();
        while (cyc < 5) tick();
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_irq_inhibit = 1'b0;
        tick();
        cfg_we = 1'b0;
        while (cyc <= 70) begin
            exp_q = (cyc inside {6, 16, 26, 36, 56, 66});
            exp_h = (cyc inside {6, 26, 56});
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== exp_h || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL five_step cyc=%0d got q=%b h=%b irq=%b exp q=%b h=%b irq=0",
                         cyc, quarter_tick, half_tick, irq, exp_q, exp_h);
            end
            tick();
        end
    endtask

    task automatic test_irq_ack();
        do_reset();
        while (cyc < 39) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_vs_set_first cyc=%0d got irq=%b exp 1", cyc, irq);
        end
        while (cyc < 45) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clear cyc=%0d got irq=%b exp 0", cyc, irq);
        end
        while (cyc < 79) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_vs_set_second cyc=%0d got irq=%b exp 1", cyc, irq);
        end
        while (cyc < 119) tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_vs_set_sticky cyc=%0d got irq=%b exp 1", cyc, irq);
        end
    endtask

    task automatic test_cfg_terminal();
        logic exp_q, exp_h;
        do_reset();
        while (cyc < 39) tick();
        cfg_we = 1'b1; cfg_mode = 1'b0; cfg_irq_inhibit = 1'b0;
        tick();
        cfg_we = 1'b0;
        while (cyc <= 52) begin
            exp_q = (cyc == 50);
            exp_h = 1'b0;
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== exp_h || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_terminal cyc=%0d got q=%b h=%b irq=%b exp q=%b h=0 irq=0",
                         cyc, quarter_tick, half_tick, irq, exp_q);
            end
            if (cyc == 40 || cyc == 50) begin
                n_tests++;
                if (step !== ((cyc == 40) ? 3'd0 : 3'd1)) begin
                    n_fail++;
                    $display("FAIL cfg_terminal_step cyc=%0d got step=%0d", cyc, step);
                end
            end
            tick();
        end
    endtask

    task automatic test_inhibit();
        logic exp_q, exp_h;
        do_reset();
        while (cyc < 42) tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL inhibit_pre cyc=%0d got irq=%b exp 1", cyc, irq);
        end
        cfg_we = 1'b1; cfg_mode = 1'b0; cfg_irq_inhibit = 1'b1;
        tick();
        cfg_we = 1'b0;
        while (cyc <= 88) begin
            exp_q = (cyc inside {53, 63, 73, 83});
            exp_h = (cyc inside {63, 83});
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== exp_h || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL inhibit cyc=%0d got q=%b h=%b irq=%b exp q=%b h=%b irq=0",
                         cyc, quarter_tick, half_tick, irq, exp_q, exp_h);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic exp_q;
        do_reset();
        while (cyc < 25) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({quarter_tick, half_tick, irq, step} !== 6'b000_000) begin
            n_fail++;
            $display("FAIL reset_mid got q=%b h=%b irq=%b step=%0d exp all 0", quarter_tick, half_tick, irq, step);
        end
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 12) begin
            tick();
            exp_q = (cyc == 10);
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_restart cyc=%0d got q=%b h=%b exp q=%b h=0", cyc, quarter_tick, half_tick, exp_q);
            end
            if (cyc == 10) begin
                n_tests++;
                if (step !== 3'd1) begin
                    n_fail++;
                    $display("FAIL reset_restart_step got step=%0d exp 1", step);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_q;
        do_reset();
        while (cyc < 5) tick();
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_irq_inhibit = 1'b0;
        tick();
        n_tests++;
        if (quarter_tick !== 1'b1 || half_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first cyc=%0d got q=%b h=%b exp 1 1", cyc, quarter_tick, half_tick);
        end
        tick();
        cfg_we = 1'b0;
        n_tests++;
        if (quarter_tick !== 1'b1 || half_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second cyc=%0d got q=%b h=%b exp 1 1", cyc, quarter_tick, half_tick);
        end
        while (cyc < 18) begin
            tick();
            exp_q = (cyc == 17);
            n_tests++;
            if (quarter_tick !== exp_q || half_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_after cyc=%0d got q=%b h=%b exp q=%b h=0", cyc, quarter_tick, half_tick, exp_q);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = 1'b0; cfg_irq_inhibit = 1'b0; irq_ack = 1'b0;
        test_reset();
        test_four_step();
        test_five_step();
        test_irq_ack();
        test_cfg_terminal();
        test_inhibit();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
